// File: rtl/mmc3_scanline_irq.sv
// mmc3_scanline_irq
//   Scanline IRQ generator for MMC3-class mappers. It counts filtered rising
//   edges of PPU A12 and pulls the cartridge IRQ line low when the programmed
//   scanline count expires. All state updates on the falling edge of CPU M2.
//
// Parameters
//   A12_FILTER : consecutive low samples of A12 needed before a high sample
//                counts as a clock (1..7).
//   REV_A      : 0 = new/Sharp (IRQ whenever the counter is 0 after a clock),
//                1 = old/NEC (IRQ only when the counter decrements to 0, or
//                    reloads to 0 from reload=1 with a nonzero old counter).
//
// Ports
//   m2          : CPU M2, the only clock (falling edge active)
//   rst_n       : asynchronous reset, active low
//   enable      : mapper-select qualifier, 0 = synchronous clear
//   romsel      : active-low $8000-$FFFF select
//   cpu_rw_in   : 1 = read, 0 = write
//   cpu_addr_in : CPU A14..A0
//   cpu_data_in : CPU data
//   ppu_a12     : PPU address bit 12
//   irq         : active-low IRQ request (registered)
//   counter     : current scanline counter, for debug
module mmc3_scanline_irq #(
  parameter int A12_FILTER = 3,
  parameter int REV_A      = 0
) (
  input  logic        m2,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        ppu_a12,
  output logic        irq,
  output logic [7:0]  counter
);

  localparam logic [2:0] FILT = 3'(A12_FILTER);

  logic [7:0] latch_q, latch_d;
  logic [7:0] counter_q, counter_d;
  logic       reload_q, reload_d;
  logic       irq_en_q, irq_en_d;
  logic       pending_q, pending_d;
  logic       irq_q, irq_d;
  logic [2:0] low_cnt_q, low_cnt_d;

  // Only A14, A13 and A0 take part in register decode.
  logic unused_addr;
  assign unused_addr = ^cpu_addr_in[12:1];

  logic       wr;
  logic [2:0] sel;
  logic       a12_clk;
  logic       step_dec;
  logic [7:0] step_cnt;
  logic       irq_en_eff;
  logic       pend_ok;

  assign wr      = ~romsel & ~cpu_rw_in;
  assign sel     = {cpu_addr_in[14:13], cpu_addr_in[0]};
  assign a12_clk = ppu_a12 && (low_cnt_q >= FILT);

  // Step result always uses the old latch, so a $C000 write on the same
  // edge only affects later reloads.
  assign step_dec = (counter_q != 8'd0) && !reload_q;
  assign step_cnt = step_dec ? counter_q - 8'd1 : latch_q;

  // A $E001 write landing on the clock edge already counts as enabled.
  assign irq_en_eff = irq_en_q | (wr && sel == 3'b111);

  // Old-style parts only fire on a real decrement or a forced reload from a
  // nonzero counter; new-style parts fire on any zero result.
  assign pend_ok = (REV_A == 0) ? 1'b1
                 : (step_dec || (reload_q && counter_q != 8'd0));

  always_comb begin
    latch_d   = latch_q;
    counter_d = counter_q;
    reload_d  = reload_q;
    irq_en_d  = irq_en_q;
    pending_d = pending_q;
    low_cnt_d = low_cnt_q;

    // A12 low-run filter; a high sample always restarts the run.
    if (ppu_a12)               low_cnt_d = 3'd0;
    else if (low_cnt_q < FILT) low_cnt_d = low_cnt_q + 3'd1;

    if (wr && sel == 3'b100) latch_d = cpu_data_in;

    // $C001 beats a coincident A12 clock: that clock is simply lost.
    if (wr && sel == 3'b101) begin
      counter_d = 8'd0;
      reload_d  = 1'b1;
    end else if (a12_clk) begin
      counter_d = step_cnt;
      reload_d  = 1'b0;
      if (step_cnt == 8'd0 && irq_en_eff && pend_ok) pending_d = 1'b1;
    end

    if (wr && sel == 3'b111) irq_en_d = 1'b1;

    // Acknowledge is applied last so it wins over a same-edge pending set.
    if (wr && sel == 3'b110) begin
      irq_en_d  = 1'b0;
      pending_d = 1'b0;
    end

    if (!enable) begin
      latch_d   = 8'd0;
      counter_d = 8'd0;
      reload_d  = 1'b0;
      irq_en_d  = 1'b0;
      pending_d = 1'b0;
      low_cnt_d = 3'd0;
    end

    irq_d = ~pending_d;
  end

  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      latch_q   <= 8'd0;
      counter_q <= 8'd0;
      reload_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      pending_q <= 1'b0;
      irq_q     <= 1'b1;
      low_cnt_q <= 3'd0;
    end else begin
      latch_q   <= latch_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      irq_en_q  <= irq_en_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      low_cnt_q <= low_cnt_d;
    end
  end

  assign irq     = irq_q;
  assign counter = counter_q;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Directed bench for mmc3_scanline_irq. Two instances share all inputs:
// dut (REV_A=0) and dut_b (REV_A=1). Inputs change just after a falling M2
// edge and outputs are sampled 1 ns after the next falling edge.
module tb_mmc3_scanline_irq;

  logic        m2 = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b1;
  logic        romsel = 1'b1;
  logic        cpu_rw_in = 1'b1;
  logic [14:0] cpu_addr_in = '0;
  logic [7:0]  cpu_data_in = '0;
  logic        ppu_a12 = 1'b0;
  logic        irq, irq_b;
  logic [7:0]  counter, counter_b;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [14:0] A_C000 = 15'h4000;
  localparam logic [14:0] A_C001 = 15'h4001;
  localparam logic [14:0] A_E000 = 15'h6000;
  localparam logic [14:0] A_E001 = 15'h6001;

  always #5 m2 = ~m2;

  mmc3_scanline_irq #(.A12_FILTER(3), .REV_A(0)) dut (
    .m2(m2), .rst_n(rst_n), .enable(enable), .romsel(romsel),
    .cpu_rw_in(cpu_rw_in), .cpu_addr_in(cpu_addr_in),
    .cpu_data_in(cpu_data_in), .ppu_a12(ppu_a12),
    .irq(irq), .counter(counter)
  );

  mmc3_scanline_irq #(.A12_FILTER(3), .REV_A(1)) dut_b (
    .m2(m2), .rst_n(rst_n), .enable(enable), .romsel(romsel),
    .cpu_rw_in(cpu_rw_in), .cpu_addr_in(cpu_addr_in),
    .cpu_data_in(cpu_data_in), .ppu_a12(ppu_a12),
    .irq(irq_b), .counter(counter_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rs, input logic rw, input logic [14:0] a,
                     input logic [7:0] d, input logic a12);
    romsel = rs; cpu_rw_in = rw; cpu_addr_in = a; cpu_data_in = d; ppu_a12 = a12;
    @(negedge m2);
    #1;
  endtask

  task automatic idle(input logic a12);
    cyc(1'b1, 1'b1, 15'h0, 8'h00, a12);
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d, input logic a12);
    cyc(1'b0, 1'b0, a, d, a12);
  endtask

  task automatic pulse(input int n_low);
    repeat (n_low) idle(1'b0);
    idle(1'b1);
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_irq", {7'd0, irq}, 8'd1);
    chk("rst_cnt", counter, 8'd0);
    chk("rst_irq_b", {7'd0, irq_b}, 8'd1);
    rst_n = 1'b1;

    // Basic countdown: latch=2, reload, enable
    wr(A_C000, 8'd2, 1'b0);
    wr(A_C001, 8'd0, 1'b0);
    wr(A_E001, 8'd0, 1'b0);
    idle(1'b1);
    chk("cd_load", counter, 8'd2);
    chk("cd_load_irq", {7'd0, irq}, 8'd1);
    pulse(3);
    chk("cd_dec1", counter, 8'd1);
    chk("cd_dec1_irq", {7'd0, irq}, 8'd1);
    pulse(3);
    chk("cd_zero", counter, 8'd0);
    chk("cd_zero_irq", {7'd0, irq}, 8'd0);
    chk("cd_zero_irq_b", {7'd0, irq_b}, 8'd0);
    wr(A_E000, 8'd0, 1'b0);
    chk("cd_ack_irq", {7'd0, irq}, 8'd1);
    chk("cd_ack_irq_b", {7'd0, irq_b}, 8'd1);

    // Filter: only two low samples before the high one
    wr(A_E001, 8'd0, 1'b0);
    idle(1'b1);
    chk("flt_short_cnt", counter, 8'd0);
    chk("flt_short_irq", {7'd0, irq}, 8'd1);
    // Long high: one clock only
    pulse(3);
    repeat (9) idle(1'b1);
    chk("flt_hold_cnt", counter, 8'd2);
    pulse(2);
    chk("flt_short2_cnt", counter, 8'd2);
    pulse(3);
    chk("flt_ok_cnt", counter, 8'd1);

    // Latch=0: REV_A=0 fires every clock, REV_A=1 never
    wr(A_C000, 8'd0, 1'b0);
    wr(A_C001, 8'd0, 1'b0);
    wr(A_E001, 8'd0, 1'b0);
    idle(1'b1);
    chk("l0_c1_cnt", counter, 8'd0);
    chk("l0_c1_irq", {7'd0, irq}, 8'd0);
    chk("l0_c1_irq_b", {7'd0, irq_b}, 8'd1);
    pulse(3);
    chk("l0_c2_irq", {7'd0, irq}, 8'd0);
    chk("l0_c2_irq_b", {7'd0, irq_b}, 8'd1);
    pulse(3);
    chk("l0_c3_cnt", counter, 8'd0);
    chk("l0_c3_irq_b", {7'd0, irq_b}, 8'd1);
    wr(A_E000, 8'd0, 1'b0);
    chk("l0_ack_irq", {7'd0, irq}, 8'd1);

    // $C001 on the same edge as an A12 clock
    wr(A_C000, 8'd5, 1'b0);
    wr(A_C001, 8'd0, 1'b0);
    idle(1'b1);
    chk("c001_pre_cnt", counter, 8'd5);
    repeat (3) idle(1'b0);
    wr(A_C001, 8'd0, 1'b1);
    chk("c001_clk_cnt", counter, 8'd0);
    pulse(3);
    chk("c001_reload_cnt", counter, 8'd5);

    // Counter reaches 0 on the same edge as $E000
    wr(A_C000, 8'd1, 1'b0);
    wr(A_C001, 8'd0, 1'b0);
    wr(A_E001, 8'd0, 1'b0);
    idle(1'b1);
    chk("e000_pre_cnt", counter, 8'd1);
    repeat (3) idle(1'b0);
    wr(A_E000, 8'd0, 1'b1);
    chk("e000_clk_cnt", counter, 8'd0);
    chk("e000_clk_irq", {7'd0, irq}, 8'd1);
    chk("e000_clk_irq_b", {7'd0, irq_b}, 8'd1);
    pulse(3);
    chk("e000_reload_cnt", counter, 8'd1);
    pulse(3);
    chk("e000_off_cnt", counter, 8'd0);
    chk("e000_off_irq", {7'd0, irq}, 8'd1);

    // $C000 with an A12 clock: old latch used, new one stored
    repeat (3) idle(1'b0);
    wr(A_C000, 8'd7, 1'b1);
    chk("c000_clk_cnt", counter, 8'd1);
    pulse(3);
    chk("c000_dec_cnt", counter, 8'd0);
    pulse(3);
    chk("c000_new_cnt", counter, 8'd7);

    // $E001 with an A12 clock that decrements to 0
    wr(A_C000, 8'd1, 1'b0);
    wr(A_C001, 8'd0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    chk("e001_pre_cnt", counter, 8'd1);
    repeat (3) idle(1'b0);
    wr(A_E001, 8'd0, 1'b1);
    chk("e001_clk_cnt", counter, 8'd0);
    chk("e001_clk_irq", {7'd0, irq}, 8'd0);
    chk("e001_clk_irq_b", {7'd0, irq_b}, 8'd0);

    // Pending is sticky across a reload to 5; async reset then clears it
    wr(A_C000, 8'd5, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    chk("ar_pre_cnt", counter, 8'd5);
    chk("ar_pre_irq", {7'd0, irq}, 8'd0);
    rst_n = 1'b0;
    #1;
    chk("ar_irq", {7'd0, irq}, 8'd1);
    chk("ar_cnt", counter, 8'd0);
    rst_n = 1'b1;
    #1;

    // enable=0 clears state on the next edge
    wr(A_C000, 8'd0, 1'b0);
    wr(A_C001, 8'd0, 1'b0);
    wr(A_E001, 8'd0, 1'b0);
    idle(1'b1);
    chk("en_pre_irq", {7'd0, irq}, 8'd0);
    wr(A_C000, 8'd3, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    chk("en_pre_cnt", counter, 8'd3);
    chk("en_pre_irq2", {7'd0, irq}, 8'd0);
    enable = 1'b0;
    idle(1'b0);
    chk("en_off_cnt", counter, 8'd0);
    chk("en_off_irq", {7'd0, irq}, 8'd1);
    enable = 1'b1;
    pulse(3);
    chk("en_latch_cnt", counter, 8'd0);
    chk("en_latch_irq", {7'd0, irq}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
